// File: rtl/count_trend_decoder.sv
// Classifies successive counter samples as HOLD/UP/DOWN/JUMP, run-length encodes
// them and streams the resulting records out through a small valid/ready FIFO.
module count_trend_decoder #(
  parameter int W     = 8,
  parameter int LW    = 6,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  cnt_in,
  input  logic          cnt_vld,
  input  logic          flush,
  input  logic          clr_ovf,
  output logic          ev_vld,
  input  logic          ev_rdy,
  output logic [1:0]    ev_class,
  output logic [LW-1:0] ev_len,
  output logic [W-1:0]  ev_start,
  output logic [W-1:0]  ev_end,
  output logic          ovf
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_RUN} state_t;
  typedef enum logic [1:0] {CL_HOLD, CL_UP, CL_DOWN, CL_JUMP} cls_t;

  typedef struct packed {
    cls_t          cls;
    logic [LW-1:0] len;
    logic [W-1:0]  first;
    logic [W-1:0]  last;
  } rec_t;

  state_t        r_state, w_state_n;
  logic [W-1:0]  r_prev, w_prev_n;
  logic [W-1:0]  r_start, w_start_n;
  cls_t          r_cls, w_cls_n, w_step;
  logic [LW-1:0] r_len, w_len_n;
  logic [W-1:0]  w_diff;

  logic          w_a_vld, w_b_vld;
  rec_t          w_a, w_b;
  logic          r_skid_vld;
  rec_t          r_skid;

  rec_t          r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr, r_wr_ptr, w_wr0, w_wr1, w_wr_ptr_n;
  logic [AW:0]   r_count;
  logic [AW+1:0] w_free;
  logic          w_pop, w_p0_vld, w_p1_vld, w_acc0, w_acc1, w_drop;
  rec_t          w_p0, w_p1, w_head;
  logic          r_ovf;

  always_comb begin
    w_diff = cnt_in - r_prev;
    if (w_diff == '0)             w_step = CL_HOLD;
    else if (w_diff == W'(1))     w_step = CL_UP;
    else if (w_diff == '1)        w_step = CL_DOWN;
    else                          w_step = CL_JUMP;
  end

  // Up to two records can close on one edge (closed run + jump, or closed run +
  // flushed new run); the first is pushed now, the second waits one edge in the skid.
  always_comb begin
    w_state_n = r_state;
    w_prev_n  = r_prev;
    w_start_n = r_start;
    w_cls_n   = r_cls;
    w_len_n   = r_len;
    w_a_vld   = 1'b0;
    w_a       = '0;
    w_b_vld   = 1'b0;
    w_b       = '0;

    case (r_state)
      S_IDLE: begin
        if (cnt_vld) begin
          w_state_n = S_TRACK;
          w_prev_n  = cnt_in;
        end
      end
      S_TRACK: begin
        if (cnt_vld) begin
          w_prev_n = cnt_in;
          if (w_step == CL_JUMP) begin
            w_a_vld = 1'b1;
            w_a     = '{cls: CL_JUMP, len: LW'(1), first: r_prev, last: cnt_in};
          end else begin
            w_state_n = S_RUN;
            w_cls_n   = w_step;
            w_len_n   = LW'(1);
            w_start_n = r_prev;
          end
        end
      end
      S_RUN: begin
        if (cnt_vld) begin
          w_prev_n = cnt_in;
          if (w_step == r_cls && r_len != '1) begin
            w_len_n = r_len + LW'(1);
          end else begin
            w_a_vld = 1'b1;
            w_a     = '{cls: r_cls, len: r_len, first: r_start, last: r_prev};
            if (w_step == CL_JUMP) begin
              w_b_vld   = 1'b1;
              w_b       = '{cls: CL_JUMP, len: LW'(1), first: r_prev, last: cnt_in};
              w_state_n = S_TRACK;
            end else begin
              w_cls_n   = w_step;
              w_len_n   = LW'(1);
              w_start_n = r_prev;
            end
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    if (flush && w_state_n == S_RUN) begin
      if (!w_a_vld) begin
        w_a_vld = 1'b1;
        w_a     = '{cls: w_cls_n, len: w_len_n, first: w_start_n, last: w_prev_n};
      end else begin
        w_b_vld = 1'b1;
        w_b     = '{cls: w_cls_n, len: w_len_n, first: w_start_n, last: w_prev_n};
      end
      w_state_n = S_TRACK;
    end
  end

  always_comb begin
    ev_vld   = (r_count != '0);
    w_pop    = ev_vld & ev_rdy;
    w_p0_vld = r_skid_vld | w_a_vld;
    w_p0     = r_skid_vld ? r_skid : w_a;
    w_p1_vld = r_skid_vld & w_a_vld;
    w_p1     = w_a;
    w_free   = (AW+2)'(DEPTH) - (AW+2)'(r_count) + (AW+2)'(w_pop);
    w_acc0   = w_p0_vld && (w_free != '0);
    w_acc1   = w_p1_vld && (w_free >= (AW+2)'(2));
    w_drop   = (w_p0_vld & ~w_acc0) | (w_p1_vld & ~w_acc1);
    w_wr0    = r_wr_ptr;
    w_wr1    = r_wr_ptr + AW'(1);
    w_wr_ptr_n = r_wr_ptr + AW'(w_acc0) + AW'(w_acc1);
    w_head   = r_mem[r_rd_ptr];
    ev_class = ev_vld ? w_head.cls   : '0;
    ev_len   = ev_vld ? w_head.len   : '0;
    ev_start = ev_vld ? w_head.first : '0;
    ev_end   = ev_vld ? w_head.last  : '0;
    ovf      = r_ovf;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_prev     <= '0;
      r_start    <= '0;
      r_cls      <= CL_HOLD;
      r_len      <= '0;
      r_skid_vld <= 1'b0;
      r_skid     <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_prev     <= w_prev_n;
      r_start    <= w_start_n;
      r_cls      <= w_cls_n;
      r_len      <= w_len_n;
      r_skid_vld <= w_b_vld;
      r_skid     <= w_b;
      r_rd_ptr   <= r_rd_ptr + AW'(w_pop);
      r_wr_ptr   <= w_wr_ptr_n;
      r_count    <= r_count + (AW+1)'(w_acc0) + (AW+1)'(w_acc1) - (AW+1)'(w_pop);
      r_ovf      <= w_drop | (r_ovf & ~clr_ovf);
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc0) r_mem[w_wr0] <= w_p0;
    if (w_acc1) r_mem[w_wr1] <= w_p1;
  end

endmodule

// File: tb/tb_count_trend_decoder.sv
// Bench for count_trend_decoder: directed record tables, classification vectors,
// and a randomized sample stream checked against a run-length reference model.
module tb_count_trend_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] cnt_in = '0;
  logic       cnt_vld = 1'b0, flush = 1'b0, clr_ovf = 1'b0, ev_rdy = 1'b1;
  logic       ev_vld, ovf;
  logic [1:0] ev_class;
  logic [5:0] ev_len;
  logic [7:0] ev_start, ev_end;

  count_trend_decoder #(.W(8), .LW(6), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_vld(cnt_vld), .flush(flush),
    .clr_ovf(clr_ovf), .ev_vld(ev_vld), .ev_rdy(ev_rdy), .ev_class(ev_class),
    .ev_len(ev_len), .ev_start(ev_start), .ev_end(ev_end), .ovf(ovf)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] HOLD = 2'd0, UP = 2'd1, DOWN = 2'd2, JUMP = 2'd3;

  typedef struct packed {
    logic [1:0] cls;
    logic [5:0] len;
    logic [7:0] s;
    logic [7:0] e;
  } rec_t;

  typedef struct { int tag; rec_t r; } exp_t;
  typedef struct { logic [7:0] p; logic [7:0] c; logic [1:0] cls; } cvec_t;

  int   errors = 0;
  int   checks = 0;
  rec_t got[$];
  rec_t mexp[$];
  exp_t exp_tab[$];
  cvec_t cvec[$];

  // observed stream and head stability while stalled
  logic hold_q = 1'b0;
  rec_t held_q;
  always @(negedge clk) begin
    rec_t cur;
    cur = '{ev_class, ev_len, ev_start, ev_end};
    if (!rst) hold_q = 1'b0;
    else begin
      if (hold_q) begin
        checks++;
        if (!ev_vld || cur !== held_q) begin
          errors++;
          $display("FAIL stable: got vld=%0b rec=%h required vld=1 rec=%h", ev_vld, cur, held_q);
        end
      end
      if (ev_vld && ev_rdy) got.push_back(cur);
      hold_q = ev_vld && !ev_rdy;
      held_q = cur;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic f);
    cnt_vld = v; cnt_in = d; flush = f;
    @(posedge clk); #1;
    cnt_vld = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    got.delete();
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int quiet;
    quiet = 0;
    for (int i = 0; i < 300 && quiet < 3; i++) begin
      @(posedge clk); #1;
      quiet = ev_vld ? 0 : quiet + 1;
    end
    if (quiet < 3) begin
      errors++; checks++;
      $display("FAIL %s_drain: got ev_vld still 1 required 0 within budget", name);
    end
  endtask

  task automatic check_tag(input int tag);
    string nm;
    nm = $sformatf("test%0d", tag);
    foreach (exp_tab[i]) begin
      if (exp_tab[i].tag == tag) begin
        checks++;
        if (got.size() == 0) begin
          errors++;
          $display("FAIL %s_rec: got none required %h", nm, exp_tab[i].r);
        end else begin
          rec_t g;
          g = got.pop_front();
          if (g !== exp_tab[i].r) begin
            errors++;
            $display("FAIL %s_rec: got %h required %h", nm, g, exp_tab[i].r);
          end
        end
      end
    end
    chk({nm, "_extra"}, got.size(), 0);
  endtask

  // reference model: spec rules over a sample stream, emitting records in order
  logic       m_have = 1'b0, m_open = 1'b0;
  logic [7:0] m_prev, m_start;
  logic [1:0] m_cls;
  int         m_len;

  function automatic logic [1:0] classify(input logic [7:0] p, input logic [7:0] c);
    int d;
    d = (int'(c) - int'(p) + 256) % 256;
    if (d == 0) return HOLD;
    if (d == 1) return UP;
    if (d == 255) return DOWN;
    return JUMP;
  endfunction

  task automatic model_step(input logic v, input logic [7:0] d, input logic f);
    logic [1:0] c;
    if (v) begin
      if (!m_have) begin
        m_have = 1'b1;
      end else begin
        c = classify(m_prev, d);
        if (m_open && (c != m_cls || m_len == 63)) begin
          mexp.push_back('{m_cls, 6'(m_len), m_start, m_prev});
          m_open = 1'b0;
        end
        if (m_open) m_len++;
        else if (c == JUMP) mexp.push_back('{JUMP, 6'd1, m_prev, d});
        else begin
          m_open = 1'b1; m_cls = c; m_len = 1; m_start = m_prev;
        end
      end
      m_prev = d;
    end
    if (f && m_open) begin
      mexp.push_back('{m_cls, 6'(m_len), m_start, m_prev});
      m_open = 1'b0;
    end
  endtask

  initial begin
    exp_tab = '{
      '{1, '{UP,   6'd3,  8'h10, 8'h13}},
      '{2, '{UP,   6'd3,  8'hFE, 8'h01}},
      '{2, '{DOWN, 6'd2,  8'h01, 8'hFF}},
      '{3, '{HOLD, 6'd1,  8'h05, 8'h05}},
      '{3, '{JUMP, 6'd1,  8'h05, 8'h40}},
      '{3, '{UP,   6'd1,  8'h40, 8'h41}},
      '{4, '{UP,   6'd63, 8'h00, 8'h3F}},
      '{4, '{UP,   6'd7,  8'h3F, 8'h46}},
      '{5, '{JUMP, 6'd1,  8'h00, 8'h10}},
      '{5, '{JUMP, 6'd1,  8'h10, 8'h20}},
      '{5, '{JUMP, 6'd1,  8'h20, 8'h30}},
      '{5, '{JUMP, 6'd1,  8'h30, 8'h40}},
      '{6, '{UP,   6'd1,  8'h55, 8'h56}}
    };
    cvec = '{
      '{8'h33, 8'h33, HOLD}, '{8'h33, 8'h34, UP},   '{8'h33, 8'h32, DOWN},
      '{8'hFF, 8'h00, UP},   '{8'h00, 8'hFF, DOWN}, '{8'h7F, 8'h80, UP},
      '{8'h80, 8'h7F, DOWN}, '{8'h10, 8'h12, JUMP}, '{8'h12, 8'h10, JUMP},
      '{8'h00, 8'h80, JUMP}
    };

    #2;
    chk("rst_vld", ev_vld, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_fields", {ev_class, ev_len, ev_start, ev_end}, 0);
    #10 rst = 1'b1;
    @(posedge clk); #1;

    // 1
    step(1, 8'h10, 0); step(1, 8'h11, 0); step(1, 8'h12, 0); step(1, 8'h13, 0);
    step(0, 8'h00, 1);
    drain("test1"); check_tag(1);
    chk("test1_ovf", ovf, 0);

    // 2
    do_reset();
    step(1, 8'hFE, 0); step(1, 8'hFF, 0); step(1, 8'h00, 0);
    step(1, 8'h01, 0); step(1, 8'h00, 0); step(1, 8'hFF, 0);
    step(0, 8'h00, 1);
    drain("test2"); check_tag(2);

    // 3
    do_reset();
    step(1, 8'h05, 0); step(1, 8'h05, 0); step(1, 8'h40, 0); step(1, 8'h41, 0);
    step(0, 8'h00, 1);
    drain("test3"); check_tag(3);

    // 4
    do_reset();
    step(1, 8'h00, 0);
    for (int i = 1; i <= 70; i++) step(1, 8'(i), 0);
    step(0, 8'h00, 1);
    drain("test4"); check_tag(4);

    // 5
    do_reset();
    ev_rdy = 1'b0;
    step(1, 8'h00, 0);
    for (int i = 1; i <= 6; i++) step(1, 8'(i * 16), 0);
    idle(3);
    chk("test5_vld_full", ev_vld, 1);
    chk("test5_ovf_set", ovf, 1);
    ev_rdy = 1'b1;
    drain("test5"); check_tag(5);
    chk("test5_ovf_sticky", ovf, 1);
    clr_ovf = 1'b1; @(posedge clk); #1; clr_ovf = 1'b0;
    chk("test5_ovf_clr", ovf, 0);

    // 6
    do_reset();
    ev_rdy = 1'b0;
    step(1, 8'h00, 0); step(1, 8'h10, 0); step(1, 8'h20, 0); step(1, 8'h21, 0);
    chk("test6_queued", ev_vld, 1);
    #2 rst = 1'b0;
    #1 chk("test6_async_vld", ev_vld, 0);
    chk("test6_async_fields", {ev_class, ev_len, ev_start, ev_end}, 0);
    got.delete();
    @(posedge clk); #3 rst = 1'b1;
    ev_rdy = 1'b1;
    step(1, 8'h55, 0);
    idle(4);
    chk("test6_first_sample", ev_vld + got.size(), 0);
    step(1, 8'h56, 1);
    drain("test6"); check_tag(6);

    // classification table, single step each, sample and flush on the same edge
    foreach (cvec[i]) begin
      rec_t g;
      do_reset();
      step(1, cvec[i].p, 0);
      step(1, cvec[i].c, 1);
      drain("cls");
      checks++;
      if (got.size() != 1) begin
        errors++;
        $display("FAIL cls%0d_count: got %0d records required 1", i, got.size());
      end else begin
        g = got.pop_front();
        if (g !== rec_t'{cvec[i].cls, 6'd1, cvec[i].p, cvec[i].c}) begin
          errors++;
          $display("FAIL cls%0d: got %h required %h", i, g,
                   rec_t'{cvec[i].cls, 6'd1, cvec[i].p, cvec[i].c});
        end
      end
    end

    // randomized stream; two idle cycles per sample keep the FIFO from filling
    do_reset();
    mexp.delete(); m_have = 1'b0; m_open = 1'b0;
    begin
      logic [7:0] rv, d;
      logic       v, f;
      int         trend;
      rv = 8'($urandom); trend = 1;
      for (int i = 0; i < 700; i++) begin
        if ($urandom_range(39) == 0) trend = $urandom_range(3);
        case (trend)
          0:       d = rv;
          1:       d = rv + 8'd1;
          2:       d = rv - 8'd1;
          default: d = 8'($urandom);
        endcase
        v = ($urandom_range(9) < 8);
        f = ($urandom_range(19) == 0);
        if (v) rv = d;
        model_step(v, d, f);
        step(v, d, f);
        idle(2);
      end
      model_step(0, 8'h00, 1);
      step(0, 8'h00, 1);
    end
    drain("rand");
    chk("rand_count", got.size(), mexp.size());
    while (got.size() > 0 && mexp.size() > 0) begin
      rec_t g, m;
      g = got.pop_front(); m = mexp.pop_front();
      checks++;
      if (g !== m) begin
        errors++;
        $display("FAIL rand_rec: got %h required %h", g, m);
      end
    end
    chk("rand_ovf", ovf, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish required finish");
    $fatal(1);
  end

endmodule
